// File: rtl/pe_pkg.sv
// Shared types and constants for the pixel processing element.
package pe_pkg;

    localparam int PIX_W = 8;

    // Bit positions of each state in the one-hot state vector.
    localparam int S_QI   = 0;
    localparam int S_QBGI = 1;
    localparam int S_QBG  = 2;
    localparam int S_QBGD = 3;
    localparam int S_QBAD = 4;
    localparam int S_QSI  = 5;
    localparam int S_QS   = 6;
    localparam int S_QSD  = 7;

    typedef enum logic [7:0] {
        ST_QI   = 8'b0000_0001,
        ST_QBGI = 8'b0000_0010,
        ST_QBG  = 8'b0000_0100,
        ST_QBGD = 8'b0000_1000,
        ST_QBAD = 8'b0001_0000,
        ST_QSI  = 8'b0010_0000,
        ST_QS   = 8'b0100_0000,
        ST_QSD  = 8'b1000_0000
    } state_e;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/pe_pixel_classify.sv
// Combinational background test: a pixel is background when every channel
// lies within thr_i of the expected colour (equality counts as background).
module pe_pixel_classify
    import pe_pkg::*;
(
    input  rgb_t             pix_i,
    input  rgb_t             exp_i,
    input  logic [PIX_W-1:0] thr_i,
    output logic             is_bg_o
);

    // Compare-then-subtract so the difference never wraps.
    function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign is_bg_o = (absdiff(pix_i.r, exp_i.r) <= thr_i) &&
                     (absdiff(pix_i.g, exp_i.g) <= thr_i) &&
                     (absdiff(pix_i.b, exp_i.b) <= thr_i);

endmodule

// File: rtl/pe.sv
// Pixel processing element: per-channel sum and background replacement over
// NUM_PIXELS packed RGB pixels, sequenced by a one-hot FSM with Ack release.
module pe
    import pe_pkg::*;
#(
    parameter int NUM_PIXELS = 1
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Ack,
    input  logic [PIX_W-1:0]            red_exp,
    input  logic [PIX_W-1:0]            green_exp,
    input  logic [PIX_W-1:0]            blue_exp,
    input  logic [PIX_W-1:0]            threshold,
    input  logic [PIX_W-1:0]            desired_bg_r,
    input  logic [PIX_W-1:0]            desired_bg_g,
    input  logic [PIX_W-1:0]            desired_bg_b,
    input  logic                        Start_Sum,
    input  logic                        Start_BgRemoval,
    input  logic [PIX_W*NUM_PIXELS-1:0] red_in,
    input  logic [PIX_W*NUM_PIXELS-1:0] green_in,
    input  logic [PIX_W*NUM_PIXELS-1:0] blue_in,
    output logic [PIX_W*NUM_PIXELS-1:0] red_out,
    output logic [PIX_W*NUM_PIXELS-1:0] green_out,
    output logic [PIX_W*NUM_PIXELS-1:0] blue_out,
    output logic                        Qi,
    output logic                        Qbgi,
    output logic                        Qbg,
    output logic                        Qbgd,
    output logic                        Qbad,
    output logic                        Qsi,
    output logic                        Qs,
    output logic                        Qsd,
    output logic [PIX_W*NUM_PIXELS-1:0] red_sum,
    output logic [PIX_W*NUM_PIXELS-1:0] green_sum,
    output logic [PIX_W*NUM_PIXELS-1:0] blue_sum
);

    localparam int VW    = PIX_W * NUM_PIXELS;
    localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIXELS - 1);

    typedef logic [NUM_PIXELS-1:0][PIX_W-1:0] chan_t;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic               idx_last;
    chan_t              r_lat_q, g_lat_q, b_lat_q;
    chan_t              r_out_q, g_out_q, b_out_q;
    rgb_t               exp_q, bg_q;
    logic [PIX_W-1:0]   thr_q;
    logic [VW-1:0]      r_sum_q, g_sum_q, b_sum_q;
    rgb_t               cur_px;
    logic               cur_is_bg;

    // Pixel under the index, taken from the latched input vectors.
    assign cur_px   = {r_lat_q[idx_q], g_lat_q[idx_q], b_lat_q[idx_q]};
    assign idx_d    = idx_q + 1'b1;
    assign idx_last = (idx_q == IDX_LAST);

    pe_pixel_classify u_classify (
        .pix_i   (cur_px),
        .exp_i   (exp_q),
        .thr_i   (thr_q),
        .is_bg_o (cur_is_bg)
    );

    // FSM, index counter, input latches, output pixels and accumulators.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_QI;
            idx_q   <= '0;
            r_lat_q <= '0;
            g_lat_q <= '0;
            b_lat_q <= '0;
            r_out_q <= '0;
            g_out_q <= '0;
            b_out_q <= '0;
            exp_q   <= '0;
            bg_q    <= '0;
            thr_q   <= '0;
            r_sum_q <= '0;
            g_sum_q <= '0;
            b_sum_q <= '0;
        end else begin
            case (state_q)
                ST_QI: begin
                    if (Start_Sum && Start_BgRemoval) state_q <= ST_QBAD;
                    else if (Start_BgRemoval)         state_q <= ST_QBGI;
                    else if (Start_Sum)               state_q <= ST_QSI;
                end
                ST_QBGI: begin
                    r_lat_q <= red_in;
                    g_lat_q <= green_in;
                    b_lat_q <= blue_in;
                    exp_q   <= {red_exp, green_exp, blue_exp};
                    bg_q    <= {desired_bg_r, desired_bg_g, desired_bg_b};
                    thr_q   <= threshold;
                    idx_q   <= '0;
                    state_q <= ST_QBG;
                end
                ST_QBG: begin
                    r_out_q[idx_q] <= cur_is_bg ? bg_q.r : cur_px.r;
                    g_out_q[idx_q] <= cur_is_bg ? bg_q.g : cur_px.g;
                    b_out_q[idx_q] <= cur_is_bg ? bg_q.b : cur_px.b;
                    idx_q          <= idx_d;
                    if (idx_last) state_q <= ST_QBGD;
                end
                ST_QSI: begin
                    r_lat_q <= red_in;
                    g_lat_q <= green_in;
                    b_lat_q <= blue_in;
                    r_sum_q <= '0;
                    g_sum_q <= '0;
                    b_sum_q <= '0;
                    idx_q   <= '0;
                    state_q <= ST_QS;
                end
                ST_QS: begin
                    r_sum_q <= r_sum_q + VW'(cur_px.r);
                    g_sum_q <= g_sum_q + VW'(cur_px.g);
                    b_sum_q <= b_sum_q + VW'(cur_px.b);
                    idx_q   <= idx_d;
                    if (idx_last) state_q <= ST_QSD;
                end
                ST_QBGD, ST_QSD, ST_QBAD: begin
                    if (Ack) state_q <= ST_QI;
                end
                default: state_q <= ST_QI;
            endcase
        end
    end

    assign Qi   = state_q[S_QI];
    assign Qbgi = state_q[S_QBGI];
    assign Qbg  = state_q[S_QBG];
    assign Qbgd = state_q[S_QBGD];
    assign Qbad = state_q[S_QBAD];
    assign Qsi  = state_q[S_QSI];
    assign Qs   = state_q[S_QS];
    assign Qsd  = state_q[S_QSD];

    assign red_out   = r_out_q;
    assign green_out = g_out_q;
    assign blue_out  = b_out_q;
    assign red_sum   = r_sum_q;
    assign green_sum = g_sum_q;
    assign blue_sum  = b_sum_q;

endmodule

// File: tb/tb_pe.sv
// Scoreboard bench for pe with four pixels per vector.
module tb_pe;

    localparam int NP = 4;
    localparam int VW = 8 * NP;

    localparam logic [7:0] F_QI   = 8'h80;
    localparam logic [7:0] F_QBGI = 8'h40;
    localparam logic [7:0] F_QBG  = 8'h20;
    localparam logic [7:0] F_QBGD = 8'h10;
    localparam logic [7:0] F_QBAD = 8'h08;
    localparam logic [7:0] F_QSI  = 8'h04;
    localparam logic [7:0] F_QS   = 8'h02;
    localparam logic [7:0] F_QSD  = 8'h01;

    logic          Clk = 1'b0;
    logic          Reset, Ack;
    logic [7:0]    red_exp, green_exp, blue_exp, threshold;
    logic [7:0]    desired_bg_r, desired_bg_g, desired_bg_b;
    logic          Start_Sum, Start_BgRemoval;
    logic [VW-1:0] red_in, green_in, blue_in;
    logic [VW-1:0] red_out, green_out, blue_out;
    logic [VW-1:0] red_sum, green_sum, blue_sum;
    logic          Qi, Qbgi, Qbg, Qbgd, Qbad, Qsi, Qs, Qsd;
    logic [7:0]    flags;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit            is_sum;
        logic [VW-1:0] r, g, b;
    } exp_t;
    exp_t sb[$];

    pe #(.NUM_PIXELS(NP)) dut (
        .Clk(Clk), .Reset(Reset), .Ack(Ack),
        .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
        .threshold(threshold),
        .desired_bg_r(desired_bg_r), .desired_bg_g(desired_bg_g), .desired_bg_b(desired_bg_b),
        .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .Qi(Qi), .Qbgi(Qbgi), .Qbg(Qbg), .Qbgd(Qbgd), .Qbad(Qbad),
        .Qsi(Qsi), .Qs(Qs), .Qsd(Qsd),
        .red_sum(red_sum), .green_sum(green_sum), .blue_sum(blue_sum)
    );

    always #5 Clk = ~Clk;

    assign flags = {Qi, Qbgi, Qbg, Qbgd, Qbad, Qsi, Qs, Qsd};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: on the first cycle of a done state, pop and compare.
    bit prev_done = 1'b0;
    always @(negedge Clk) begin
        exp_t e;
        if (!Reset) begin
            prev_done = 1'b0;
        end else begin
            if ((Qbgd || Qsd) && !prev_done) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_done", 64'(flags), 64'(F_QI));
                end else begin
                    e = sb.pop_front();
                    if (e.is_sum) begin
                        check("sb_kind_sum", 64'(Qsd), 64'd1);
                        check("sb_red_sum",   64'(red_sum),   64'(e.r));
                        check("sb_green_sum", 64'(green_sum), 64'(e.g));
                        check("sb_blue_sum",  64'(blue_sum),  64'(e.b));
                    end else begin
                        check("sb_kind_bg", 64'(Qbgd), 64'd1);
                        check("sb_red_out",   64'(red_out),   64'(e.r));
                        check("sb_green_out", 64'(green_out), 64'(e.g));
                        check("sb_blue_out",  64'(blue_out),  64'(e.b));
                    end
                end
            end
            prev_done = Qbgd || Qsd;
        end
    end

    // Count cycles spent in a busy state, bounded.
    task automatic count_state(input logic [7:0] st, output int n);
        n = 0;
        while (flags == st && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic scramble();
        red_in   = $urandom;
        green_in = $urandom;
        blue_in  = $urandom;
        red_exp  = 8'($urandom);
        threshold = 8'($urandom);
        desired_bg_r = 8'($urandom);
    endtask

    task automatic run_sum(input logic [VW-1:0] r, g, b,
                           input logic [VW-1:0] er, eg, eb);
        int n;
        exp_t e;
        red_in = r; green_in = g; blue_in = b;
        e.is_sum = 1'b1; e.r = er; e.g = eg; e.b = eb;
        sb.push_back(e);
        Start_Sum = 1'b1;
        tick();
        Start_Sum = 1'b0;
        check("sum_qsi", 64'(flags), 64'(F_QSI));
        tick();
        scramble();
        count_state(F_QS, n);
        check("sum_qs_cycles", 64'(n), 64'(NP));
        check("sum_qsd", 64'(flags), 64'(F_QSD));
        tick();
        check("sum_release", 64'(flags), 64'(F_QI));
    endtask

    task automatic run_bg(input logic [VW-1:0] r, g, b,
                          input logic [7:0] xr, xg, xb, th, dr, dg, db,
                          input logic [VW-1:0] er, eg, eb,
                          input bit poke_sum);
        int n;
        exp_t e;
        red_in = r; green_in = g; blue_in = b;
        red_exp = xr; green_exp = xg; blue_exp = xb; threshold = th;
        desired_bg_r = dr; desired_bg_g = dg; desired_bg_b = db;
        e.is_sum = 1'b0; e.r = er; e.g = eg; e.b = eb;
        sb.push_back(e);
        Start_BgRemoval = 1'b1;
        tick();
        Start_BgRemoval = 1'b0;
        check("bg_qbgi", 64'(flags), 64'(F_QBGI));
        tick();
        scramble();
        if (poke_sum) Start_Sum = 1'b1;
        tick();
        Start_Sum = 1'b0;
        count_state(F_QBG, n);
        check("bg_qbg_cycles", 64'(n + 1), 64'(NP));
        check("bg_qbgd", 64'(flags), 64'(F_QBGD));
        if (Ack) begin
            tick();
            check("bg_release", 64'(flags), 64'(F_QI));
        end
    endtask

    initial begin
        Reset = 1'b0; Ack = 1'b0;
        Start_Sum = 1'b0; Start_BgRemoval = 1'b0;
        red_exp = '0; green_exp = '0; blue_exp = '0; threshold = '0;
        desired_bg_r = '0; desired_bg_g = '0; desired_bg_b = '0;
        red_in = '0; green_in = '0; blue_in = '0;

        // Reset sequence
        repeat (5) @(posedge Clk);
        #1;
        check("rst_flags", 64'(flags), 64'(F_QI));
        check("rst_outs", 64'({red_out, green_out, blue_out}), 64'd0);
        check("rst_sums", 64'({red_sum, green_sum, blue_sum}), 64'd0);
        @(negedge Clk);
        Reset = 1'b1;
        tick();
        check("idle_flags", 64'(flags), 64'(F_QI));

        // Single-pixel sum, Ack held high
        Ack = 1'b1;
        run_sum(32'h0000_003D, 32'h0000_0085, 32'h0000_00C6, 32'd61, 32'd133, 32'd198);
        tick(); tick();
        check("sum_hold_r", 64'(red_sum), 64'd61);
        check("sum_hold_b", 64'(blue_sum), 64'd198);
        check("sum_outs_untouched", 64'(red_out), 64'd0);

        // Exact match on every pixel
        run_bg(32'h3D3D3D3D, 32'h85858585, 32'hC6C6C6C6, 8'd61, 8'd133, 8'd198,
               8'd30, 8'd10, 8'd10, 8'd10,
               32'h0A0A0A0A, 32'h0A0A0A0A, 32'h0A0A0A0A, 1'b0);
        check("bg_sums_untouched", 64'(green_sum), 64'd133);

        // Threshold boundary, pass-through and no-wrap (pixel 0 below exp)
        run_bg(32'h64638382, 32'h64656446, 32'h45476464, 8'd100, 8'd100, 8'd100,
               8'd30, 8'h0A, 8'h14, 8'h1E,
               32'h640A830A, 32'h64146414, 32'h451E641E, 1'b0);

        // threshold = 0: exact matches only
        run_bg(32'h32323332, 32'h3B3C3C3C, 32'h46474646, 8'd50, 8'd60, 8'd70,
               8'd0, 8'd1, 8'd2, 8'd3,
               32'h32323301, 32'h3B3C3C02, 32'h46474603, 1'b0);

        // threshold = 255: every pixel replaced
        run_bg(32'hFF00807F, 32'h01FE1234, 32'hFFFFFFFF, 8'd0, 8'd0, 8'd0,
               8'd255, 8'hAA, 8'hBB, 8'hCC,
               32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 1'b0);

        // Four-pixel sums including full-scale red
        run_sum(32'hFFFFFFFF, 32'h01020304, 32'h80808080, 32'd1020, 32'd10, 32'd512);
        check("outs_held_r", 64'(red_out), 64'hAAAAAAAA);
        check("outs_held_b", 64'(blue_out), 64'hCCCCCCCC);

        // Ack low in Qbgd; start pulse during Qbg ignored
        Ack = 1'b0;
        run_bg(32'h64638382, 32'h64656446, 32'h45476464, 8'd100, 8'd100, 8'd100,
               8'd30, 8'h0A, 8'h14, 8'h1E,
               32'h640A830A, 32'h64146414, 32'h451E641E, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("qbgd_wait", 64'(flags), 64'(F_QBGD));
        end
        Ack = 1'b1;
        tick();
        check("qbgd_ack", 64'(flags), 64'(F_QI));
        Ack = 1'b0;
        tick();
        check("poke_ignored_state", 64'(flags), 64'(F_QI));
        check("poke_ignored_sum", 64'(red_sum), 64'd1020);

        // Simultaneous start -> Qbad, nothing changes
        red_in = 32'h11111111;
        Start_Sum = 1'b1; Start_BgRemoval = 1'b1;
        tick();
        Start_Sum = 1'b0; Start_BgRemoval = 1'b0;
        check("bad_state", 64'(flags), 64'(F_QBAD));
        tick(); tick();
        check("bad_hold", 64'(flags), 64'(F_QBAD));
        check("bad_outs", 64'(red_out), 64'h640A830A);
        check("bad_sums", 64'(blue_sum), 64'd512);
        Ack = 1'b1;
        tick();
        check("bad_ack", 64'(flags), 64'(F_QI));

        // Ack ignored in idle
        tick(); tick();
        check("ack_idle", 64'(flags), 64'(F_QI));
        Ack = 1'b0;

        // Asynchronous reset while in Qbg
        Start_BgRemoval = 1'b1;
        tick();
        Start_BgRemoval = 1'b0;
        tick(); tick();
        check("abort_in_qbg", 64'(flags), 64'(F_QBG));
        #2 Reset = 1'b0;
        #1;
        check("abort_flags", 64'(flags), 64'(F_QI));
        check("abort_outs", 64'({red_out, green_out, blue_out}), 64'd0);
        check("abort_sums", 64'({red_sum, green_sum, blue_sum}), 64'd0);
        @(negedge Clk);
        Reset = 1'b1;
        tick();
        check("post_abort_idle", 64'(flags), 64'(F_QI));

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Safety net against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pe.md
Name: pe

Overview:
- Pixel processing element for the background-removal datapath; operates on NUM_PIXELS packed RGB pixels (8 bits per channel).
- Two operations, each started by a one-cycle pulse and closed by an Ack handshake:
  - Channel sum: accumulates each colour channel over all pixels. Upstream uses the sums to form the expected background colour (mean).
  - Background replacement: compares each pixel to an expected colour. Pixels within the threshold on every channel are replaced by the desired background colour; all other pixels pass through unchanged.
- One-hot state is exported for system-level sequencing and debug.

Parameters:
- NUM_PIXELS, 1, number of pixels packed in each channel vector; pixel i occupies bits [8i+7:8i].

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- Ack  in  1  acknowledge; releases the FSM from Qbgd, Qsd or Qbad.
- red_exp, green_exp, blue_exp  in  8 each  expected background colour.
- threshold  in  8  maximum per-channel absolute difference still classed as background.
- desired_bg_r, desired_bg_g, desired_bg_b  in  8 each  replacement colour.
- Start_Sum  in  1  start pulse for the sum operation.
- Start_BgRemoval  in  1  start pulse for the replacement operation.
- red_in, green_in, blue_in  in  8*NUM_PIXELS each  input pixels.
- red_out, green_out, blue_out  out  8*NUM_PIXELS each  processed pixels (registered).
- Qi, Qbgi, Qbg, Qbgd, Qbad, Qsi, Qs, Qsd  out  1 each  one-hot state flags.
- red_sum, green_sum, blue_sum  out  8*NUM_PIXELS each  channel sums, zero-extended (registered).

Behaviour:
- Single one-hot FSM. Exactly one Q* flag is high at all times.
- Reset (asynchronous, active-low):
  - State goes to Qi. The pixel index, all *_out and all *_sum clear to 0.
  - Reset asserted mid-operation aborts the operation immediately, with the same values.
- Qi (idle):
  - Start_BgRemoval alone -> Qbgi.
  - Start_Sum alone -> Qsi.
  - Both asserted in the same cycle -> Qbad.
  - Neither -> stay in Qi.
- Qbgi:
  - Latch red_in/green_in/blue_in, the *_exp colour, threshold and the desired_bg colour.
  - Index <= 0. Next state Qbg.
- Qbg (one pixel per cycle, pixel = index):
  - Compute dR = |r - red_exp|, dG = |g - green_exp|, dB = |b - blue_exp| using 9-bit signed or compare-and-subtract arithmetic, with no wrap.
  - If dR <= threshold and dG <= threshold and dB <= threshold: write the desired_bg colour to that pixel's slot in *_out.
  - Otherwise write the latched input pixel to *_out.
  - Index increments each cycle. After the pixel with index NUM_PIXELS-1 -> Qbgd.
  - Latency: Start pulse to Qbgd = NUM_PIXELS + 2 cycles.
- Qbgd (done): *_out holds. Ack high -> Qi; otherwise stay.
- Qsi:
  - Latch input pixels. Clear *_sum to 0. Index <= 0. Next state Qs.
- Qs:
  - Each *_sum += the zero-extended 8-bit channel value of pixel[index], one pixel per cycle.
  - After the last pixel -> Qsd.
  - Width 8*NUM_PIXELS is always at least 8 + ceil(log2 NUM_PIXELS), so no overflow is possible.
- Qsd: *_sum holds. Ack high -> Qi.
- Qbad (illegal simultaneous request):
  - No outputs change. Ack high -> Qi.
- Output holding:
  - *_out and *_sum keep their values through Qi and through the other operation.
  - They are overwritten only by their own operation.
- Ack:
  - Ignored outside Qbgd, Qsd and Qbad.
  - Ack already high on entry to a done state releases the FSM after exactly one cycle in that state.
- Start pulses outside Qi are ignored, with no queuing.
- Inputs need only be valid in the start cycle plus one, because they are latched in Qbgi/Qsi.
- Threshold boundary: a difference equal to threshold counts as background. threshold = 0 replaces only exact matches. threshold = 255 replaces every pixel.

Decomposition:
- Shared package pe_pkg:
  - State encoding constants (one-hot indices for Qi…Qsd).
  - Pixel width constant PIX_W = 8.
  - An RGB pixel struct typedef.
- One natural sub-module, pe_pixel_classify: purely combinational.
  - Inputs: pixel RGB, expected RGB, threshold.
  - Output: is_bg flag.
- The FSM, index counter, latches and accumulators live in pe.

Test Plan:
- Reset sequence:
  - Stimulus: hold Reset low for 5 cycles, then release.
  - Required: Qi=1, all other flags 0, all *_out and *_sum = 0. Also assert Reset low while in Qbg -> Qi=1 asynchronously and outputs 0.
- Sum, NUM_PIXELS=1:
  - Stimulus: in = (61,133,198), Start_Sum for one cycle, Ack held high.
  - Required: Qsi -> Qs -> Qsd -> Qi. red_sum=61, green_sum=133, blue_sum=198, held afterwards.
- Replacement, match case:
  - Stimulus: in = exp = (61,133,198), threshold=30, desired=(10,10,10), Start_BgRemoval pulse.
  - Required: after Qbgd, out = (10,10,10).
- Replacement, boundary and pass-through:
  - Stimulus: exp=(100,100,100), threshold=30.
  - Required: in=(130,70,100) -> out=(10,10,10). in=(131,100,100) -> out=(131,100,100). Pixel 0 diffs also verify no wrap.
- NUM_PIXELS=4 mixed pixels:
  - Stimulus: per-pixel mix of background and foreground.
  - Required: per-pixel correct replacement. Qbg lasts exactly 4 cycles. Sums equal the per-channel totals (e.g. 4x255 = 1020).
- Handshake and illegal request:
  - Stimulus: Start_Sum and Start_BgRemoval together.
  - Required: Qbad, outputs unchanged; Ack -> Qi.
  - Stimulus: Ack low in Qbgd for 3 cycles.
  - Required: FSM stays in Qbgd. A start pulse during Qbg is ignored.
